exception_ctrl: RTL
===================

// Module: exception_ctrl
// PURPOSE
//  Sequences exception entry/return for the single-cycle LEGv8 core.
//  - Takes sync causes from maindec (EStatus) and the raw ExtIRQ line.
//  - Redirects the PC to the vector, captures ELR/ESR and masks IRQs while in the handler.
//  - Releases the mask on ERET and halts the core on a double fault.
// PARAMETERS
//  N           64     datapath / PC width
//  EXC_VECTOR  64'hD8 handler entry address driven on ExcVector
// PORTS
//  clk        in   1  clock; all state updates on rising edge
//  reset      in   1  synchronous, active-high
//  ExtIRQ     in   1  asynchronous level from external device
//  EStatus    in   4  maindec cause; bit0 (ExtIRQ) ignored here, bits[3:1] = sync causes
//  ERet       in   1  current instruction is ERET (from maindec)
//  PC         in   N  PC of the instruction in flight
//  ELRWe      in   1  handler write of ELR (MSR path)
//  ELRIn      in   N  data for ELRWe
//  Exc        out  1  redirect PC to ExcVector; squash RegWrite/MemWrite this cycle
//  ExcVector  out  N  constant EXC_VECTOR
//  ELR        out  N  exception link register (return PC used by ERET)
//  ESR        out  4  latched cause code
//  IRQMask    out  1  1 while in handler
//  ExcAck     out  1  1-cycle IRQ acknowledge to device
//  Halt       out  1  double fault; core must freeze PC and squash writes
// BEHAVIOUR
//  - Reset: state RUN; ELR=0, ESR=0, IRQMask=0, ExcAck=0, Halt=0, Exc=0; synchronizer and pending cleared.
//  - IRQ path: 2-flop synchronizer, then rising-edge detect.
//    - A detected edge sets IrqPend at the next edge.
//    - With ExtIRQ high before edge 1, IrqPend=1 after edge 3.
//    - Further edges while pending are absorbed (single pending bit).
//  - Cause selection: SyncCause = EStatus & 4'b1110, or ESR_BADERET when ERet is high in RUN.
//    - SyncCause != 0 wins over IrqPend.
//  - States (exc_state_t):
//    - RUN:
//      - Exc = (SyncCause!=0) | IrqPend, combinational, same cycle.
//      - On Exc: ELR<=PC, ESR<=SyncCause (or ESR_EXTIRQ for IRQ), IRQMask<=1, state<=HANDLER.
//      - If the cause was IRQ: IrqPend<=0 and ExcAck=1 in the next cycle only.
//    - HANDLER:
//      - Exc=0; IrqPend may set but is not taken and not acked.
//      - ELRWe: ELR<=ELRIn.
//      - ERet: IRQMask<=0, state<=RUN; ELR/ESR hold.
//      - A still-pending IRQ is taken in the first RUN cycle.
//      - SyncCause!=0 (EStatus bits[3:1]): state<=FAULT, ESR<=cause|ESR_DOUBLE, ERet ignored that cycle.
//    - FAULT:
//      - Halt=1, Exc=0, ExcAck=0; all registers frozen.
//      - Exit only by reset.
//  - Simultaneous events:
//    - ELRWe with an entry in RUN: entry capture wins (ELRWe only honoured in HANDLER).
//    - ERet with SyncCause in HANDLER: FAULT wins.
//  - Reset mid-handler or in FAULT: full return to reset values; a pending IRQ is dropped.
//  - Exc is the only combinational output (from state/IrqPend/inputs); all others are registered.
// STRUCTURE
//  - exc_pkg:
//    - exc_state_t {RUN, HANDLER, FAULT}
//    - ESR_NONE=4'b0000, ESR_EXTIRQ=4'b0001, ESR_INVOP=4'b0010
//    - ESR_BADERET=4'b0100, ESR_DOUBLE=4'b1000
//  - Sub-module irq_pending: synchronizer + edge detect + pending bit.
//    - Ports: clk, reset, ExtIRQ, clr, IrqPend.
//  - FSM and ELR/ESR registers stay in exception_ctrl.
// TESTING
//  1. Reset held 2 cycles -> all outputs 0, ExcVector=64'hD8.
//  2. RUN, EStatus=4'b0010, PC=0x40 -> Exc=1 same cycle; next cycle ESR=4'b0010, ELR=0x40, IRQMask=1, ExcAck=0.
//  3. RUN, ExtIRQ 0->1 before edge 1, PC=0x20 -> Exc=1 after edge 3; then ESR=4'b0001, ELR=0x20, ExcAck=1 for exactly one cycle.
//  4. HANDLER, ExtIRQ pulse -> Exc stays 0; ERet -> IRQMask=0, and in the first RUN cycle Exc=1 with ESR=0001.
//  5. HANDLER, EStatus=4'b0010 -> Halt=1, ESR=4'b1010; further EStatus/ERet/ExtIRQ leave Exc=0; reset clears Halt.
//  6. RUN, EStatus=0010 and IrqPend=1 together -> ESR=0010, IRQ not acked; after ERet -> IRQ taken, ExcAck pulse.
//  7. RUN, ERet=1 -> Exc=1, ESR=4'b0100.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and cause codes for the LEGv8 exception controller.
package exc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    FAULT   = 2'd2
  } exc_state_t;

  localparam logic [3:0] ESR_NONE    = 4'b0000;
  localparam logic [3:0] ESR_EXTIRQ  = 4'b0001;
  localparam logic [3:0] ESR_INVOP   = 4'b0010;
  localparam logic [3:0] ESR_BADERET = 4'b0100;
  localparam logic [3:0] ESR_DOUBLE  = 4'b1000;

  // EStatus bit0 mirrors ExtIRQ from maindec; only bits[3:1] are synchronous causes.
  localparam logic [3:0] SYNC_CAUSE_MASK = 4'b1110;

endpackage

// File: rtl/irq_pending.sv
// External IRQ conditioning: 2-flop synchronizer, rising-edge detect and a
// single sticky pending bit cleared when the controller takes the interrupt.
module irq_pending (
  input  logic clk,
  input  logic reset,
  input  logic ExtIRQ,
  input  logic clr,
  output logic IrqPend
);

  logic sync1_reg;
  logic sync2_reg;
  logic sync2_d_reg;
  logic pend_reg;
  logic pend_next;
  logic irq_rise;

  assign irq_rise = sync2_reg & ~sync2_d_reg;

  // A fresh edge in the same cycle as the clear must not be lost.
  always_comb begin
    pend_next = pend_reg;
    if (irq_rise) begin
      pend_next = 1'b1;
    end else if (clr) begin
      pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      sync2_d_reg <= 1'b0;
      pend_reg    <= 1'b0;
    end else begin
      sync1_reg   <= ExtIRQ;
      sync2_reg   <= sync1_reg;
      sync2_d_reg <= sync2_reg;
      pend_reg    <= pend_next;
    end
  end

  assign IrqPend = pend_reg;

endmodule

// File: rtl/exception_ctrl.sv
// Exception entry/return sequencer for the single-cycle LEGv8 core:
// PC redirect, ELR/ESR capture, IRQ masking, ERET and double-fault halt.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int             N          = 64,
  parameter logic [N-1:0]   EXC_VECTOR = 'hD8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ExtIRQ,
  input  logic [3:0]   EStatus,
  input  logic         ERet,
  input  logic [N-1:0] PC,
  input  logic         ELRWe,
  input  logic [N-1:0] ELRIn,
  output logic         Exc,
  output logic [N-1:0] ExcVector,
  output logic [N-1:0] ELR,
  output logic [3:0]   ESR,
  output logic         IRQMask,
  output logic         ExcAck,
  output logic         Halt
);

  exc_state_t   state_reg, state_next;
  logic [N-1:0] elr_reg, elr_next;
  logic [3:0]   esr_reg, esr_next;
  logic         mask_reg, mask_next;
  logic         ack_reg, ack_next;
  logic         halt_reg, halt_next;

  logic         irq_pend;
  logic         irq_clr;
  logic [3:0]   sync_bits;
  logic [3:0]   run_cause;

  irq_pending u_irq_pending (
    .clk     (clk),
    .reset   (reset),
    .ExtIRQ  (ExtIRQ),
    .clr     (irq_clr),
    .IrqPend (irq_pend)
  );

  // ERET outside a handler is itself an exception cause.
  assign sync_bits = EStatus & SYNC_CAUSE_MASK;
  assign run_cause = sync_bits | (ERet ? ESR_BADERET : ESR_NONE);

  always_comb begin
    state_next = state_reg;
    elr_next   = elr_reg;
    esr_next   = esr_reg;
    mask_next  = mask_reg;
    ack_next   = 1'b0;
    halt_next  = halt_reg;
    irq_clr    = 1'b0;
    Exc        = 1'b0;

    case (state_reg)
      RUN: begin
        if ((run_cause != ESR_NONE) || irq_pend) begin
          Exc        = 1'b1;
          elr_next   = PC;
          mask_next  = 1'b1;
          state_next = HANDLER;
          if (run_cause != ESR_NONE) begin
            esr_next = run_cause;
          end else begin
            esr_next = ESR_EXTIRQ;
            ack_next = 1'b1;
            irq_clr  = 1'b1;
          end
        end
      end

      HANDLER: begin
        // A synchronous fault inside the handler overrides ERET and ELR writes.
        if (sync_bits != ESR_NONE) begin
          esr_next   = sync_bits | ESR_DOUBLE;
          halt_next  = 1'b1;
          state_next = FAULT;
        end else begin
          if (ELRWe) begin
            elr_next = ELRIn;
          end
          if (ERet) begin
            mask_next  = 1'b0;
            state_next = RUN;
          end
        end
      end

      FAULT: begin
        // Frozen until reset.
      end

      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      elr_reg   <= '0;
      esr_reg   <= ESR_NONE;
      mask_reg  <= 1'b0;
      ack_reg   <= 1'b0;
      halt_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      elr_reg   <= elr_next;
      esr_reg   <= esr_next;
      mask_reg  <= mask_next;
      ack_reg   <= ack_next;
      halt_reg  <= halt_next;
    end
  end

  assign ExcVector = EXC_VECTOR;
  assign ELR       = elr_reg;
  assign ESR       = esr_reg;
  assign IRQMask   = mask_reg;
  assign ExcAck    = ack_reg;
  assign Halt      = halt_reg;

endmodule
